// File: rtl/trojan_probe_ctrl.sv
// Hardware-trojan probe: sweeps all eight {A,B,C} vectors into a circuit under test,
// compares each settled response with the golden function and records the failures.
module trojan_probe_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] dut_vec,
    input  logic [3:0] dut_resp,
    output logic       busy,
    output logic       done,
    output logic       trojan_flag,
    output logic [3:0] mismatch_cnt,
    output logic [7:0] fail_mask,
    output logic [2:0] first_fail_vec,
    output logic [3:0] first_fail_bits,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_vec;
    logic [3:0] r_mcnt;
    logic [7:0] r_mask;
    logic [2:0] r_ffv;
    logic [3:0] r_ffb;

    logic [3:0] w_golden;
    logic [3:0] w_diff;
    logic       w_fail;

    // Golden response bits {E,F,G,H} for the vector currently applied.
    assign w_golden = {r_vec[2] & r_vec[1],
                       r_vec[2] | r_vec[0],
                       ~r_vec[0],
                       r_vec[2] & r_vec[1] & r_vec[0]};
    assign w_diff   = dut_resp ^ w_golden;
    assign w_fail   = (w_diff != 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_vec   <= 3'd0;
            r_mcnt  <= 4'd0;
            r_mask  <= 8'd0;
            r_ffv   <= 3'd0;
            r_ffb   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= 4'd0;
                        r_vec   <= 3'd0;
                        r_mcnt  <= 4'd0;
                        r_mask  <= 8'd0;
                        r_ffv   <= 3'd0;
                        r_ffb   <= 4'd0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (w_fail) begin
                        r_mask[r_vec] <= 1'b1;
                        r_mcnt        <= r_mcnt + 4'd1;
                        // Only the lowest failing vector is captured in a sweep.
                        if (r_mcnt == 4'd0) begin
                            r_ffv <= r_vec;
                            r_ffb <= w_diff;
                        end
                    end
                    if (r_vec == 3'd7) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SETTLE;
                        r_vec   <= r_vec + 3'd1;
                        r_cnt   <= 4'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_vec         = r_vec;
    assign busy            = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done            = (r_state == S_DONE);
    assign trojan_flag     = (r_mcnt != 4'd0);
    assign mismatch_cnt    = r_mcnt;
    assign fail_mask       = r_mask;
    assign first_fail_vec  = r_ffv;
    assign first_fail_bits = r_ffb;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_trojan_probe_ctrl.sv
// Directed plus randomized sweeps of trojan_probe_ctrl (SETTLE=2 and SETTLE=1 instances)
// against a behavioural model of the circuit under test and its expected sweep results.
module tb_trojan_probe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       sel;
    int         mode;
    logic [3:0] flt [8];

    logic [2:0] vec0, vec1, ffv0, ffv1;
    logic [3:0] resp0, resp1, mcnt0, mcnt1, ffb0, ffb1;
    logic [7:0] mask0, mask1;
    logic [1:0] st0, st1;
    logic       busy0, busy1, done0, done1, flag0, flag1;
    logic       start0, start1;

    logic [2:0] m_vec, m_ffv;
    logic [3:0] m_mcnt, m_ffb;
    logic [7:0] m_mask;
    logic       m_busy, m_done, m_flag;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_cnt;
    logic [7:0] exp_mask;
    logic [2:0] exp_ffv;
    logic [3:0] exp_ffb;

    assign start0 = sel ? 1'b0 : start;
    assign start1 = sel ? start : 1'b0;

    trojan_probe_ctrl #(.SETTLE(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_vec(vec0), .dut_resp(resp0),
        .busy(busy0), .done(done0), .trojan_flag(flag0), .mismatch_cnt(mcnt0),
        .fail_mask(mask0), .first_fail_vec(ffv0), .first_fail_bits(ffb0), .dbg_state(st0)
    );

    trojan_probe_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_vec(vec1), .dut_resp(resp1),
        .busy(busy1), .done(done1), .trojan_flag(flag1), .mismatch_cnt(mcnt1),
        .fail_mask(mask1), .first_fail_vec(ffv1), .first_fail_bits(ffb1), .dbg_state(st1)
    );

    assign m_vec  = sel ? vec1  : vec0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_flag = sel ? flag1 : flag0;
    assign m_mcnt = sel ? mcnt1 : mcnt0;
    assign m_mask = sel ? mask1 : mask0;
    assign m_ffv  = sel ? ffv1  : ffv0;
    assign m_ffb  = sel ? ffb1  : ffb0;

    function automatic logic [3:0] golden(input logic [2:0] v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return {a & b, a | c, ~c, a & b & c};
    endfunction

    // Circuit-under-test behaviours: clean, H trojan, G stuck-at-0, arbitrary fault table.
    function automatic logic [3:0] cut_out(input int md, input logic [2:0] v, input logic [3:0] f);
        logic [3:0] g;
        logic a, b, c;
        g = golden(v);
        a = v[2]; b = v[1]; c = v[0];
        case (md)
            0: return g;
            1: return {g[3:1], (a & b & c) | ~(a & ~c)};
            2: return {g[3:2], 1'b0, g[0]};
            default: return g ^ f;
        endcase
    endfunction

    always_comb begin
        resp0 = cut_out(mode, vec0, flt[vec0]);
        resp1 = cut_out(mode, vec1, flt[vec1]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_sweep();
        logic [3:0] d;
        exp_cnt = 4'd0; exp_mask = 8'd0; exp_ffv = 3'd0; exp_ffb = 4'd0;
        for (int v = 0; v < 8; v++) begin
            d = cut_out(mode, 3'(v), flt[v]) ^ golden(3'(v));
            if (d != 4'd0) begin
                if (exp_cnt == 4'd0) begin
                    exp_ffv = 3'(v);
                    exp_ffb = d;
                end
                exp_mask[v] = 1'b1;
                exp_cnt++;
            end
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_cnt"},  m_mcnt, exp_cnt);
        chk({tag, "_mask"}, m_mask, exp_mask);
        chk({tag, "_ffv"},  m_ffv,  exp_ffv);
        chk({tag, "_ffb"},  m_ffb,  exp_ffb);
        chk({tag, "_flag"}, m_flag, exp_cnt != 0);
    endtask

    // Called right after the acceptance edge; returns at the negedge inside DONE
    // (keep_start=1) or one cycle later with start released.
    task automatic run_to_done(input int s, input bit noisy, input bit keep_start);
        int n, bad_vec, bad_busy, ev;
        model_sweep();
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        chk("accept_busy", m_busy, 1);
        chk("accept_vec", m_vec, 0);
        chk("accept_clear", {m_mcnt, m_mask, m_ffv, m_ffb}, 0);
        n = 0; bad_vec = 0; bad_busy = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (m_done) break;
            ev = n / (s + 1);
            if (m_vec !== 3'(ev)) bad_vec++;
            if (m_busy !== 1'b1) bad_busy++;
            if (noisy) start = 1'($urandom_range(0, 1));
        end
        if (!keep_start) start = 1'b0;
        chk("done_latency", n, 8 * (s + 1));
        chk("vec_sequence_errors", bad_vec, 0);
        chk("busy_gap_errors", bad_busy, 0);
        chk("busy_in_done", m_busy, 0);
        chk("vec_in_done", m_vec, 7);
        chk_results("done");
        if (!keep_start) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_pulse_width", m_done, 0);
            chk("idle_busy", m_busy, 0);
            chk("idle_vec_hold", m_vec, 7);
            chk_results("hold");
        end
    endtask

    task automatic launch(input int s, input bit noisy);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        run_to_done(s, noisy, 1'b0);
    endtask

    initial begin
        int n, ndone;
        rst_n = 1'b0; start = 1'b1; sel = 1'b0; mode = 0;
        for (int i = 0; i < 8; i++) flt[i] = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs0", {vec0, busy0, done0, flag0, mcnt0, mask0, ffv0, ffb0}, 0);
        chk("reset_outs1", {vec1, busy1, done1, flag1, mcnt1, mask1, ffv1, ffb1}, 0);
        start = 1'b0;
        rst_n = 1'b1;

        // Clean circuit, SETTLE=2.
        launch(2, 1'b0);
        chk("golden_flag", m_flag, 0);

        // H trojan.
        mode = 1;
        launch(2, 1'b0);
        chk("trojan_cnt", m_mcnt, 5);
        chk("trojan_mask", m_mask, 8'h2F);
        chk("trojan_ffb", m_ffb, 4'b0001);

        // G stuck-at-0.
        mode = 2;
        launch(2, 1'b0);
        chk("stuck_cnt", m_mcnt, 4);
        chk("stuck_mask", m_mask, 8'h55);
        chk("stuck_ffb", m_ffb, 4'b0010);

        // start toggling during the sweep must not disturb it.
        mode = 1;
        launch(2, 1'b1);

        // Reset in the middle of a sweep while start is asserted.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (m_vec !== 3'd3 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("reach_vec3", m_vec, 3);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_outs", {m_vec, m_busy, m_done, m_flag, m_mcnt, m_mask, m_ffv, m_ffb}, 0);
        rst_n = 1'b1;
        start = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (m_done || m_busy) ndone++;
        end
        chk("no_activity_after_reset", ndone, 0);
        mode = 0;
        launch(2, 1'b0);

        // start held high: back-to-back sweeps.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        run_to_done(2, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_done", m_done, 0);
        chk("b2b_idle_busy", m_busy, 0);
        chk_results("b2b_idle");
        @(posedge clk);
        run_to_done(2, 1'b0, 1'b0);

        // SETTLE=1 instance.
        sel = 1'b1;
        mode = 0;
        launch(1, 1'b0);
        mode = 2;
        launch(1, 1'b0);

        // Randomized fault tables on either instance.
        mode = 3;
        for (int k = 0; k < 8; k++) begin
            sel = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++)
                flt[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            launch(sel ? 1 : 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trojan_probe_ctrl.md
TROJAN_PROBE_CTRL -- requirements
Module: trojan_probe_ctrl

Interface
REQ-001 Parameter: SETTLE, default 2, number of cycles each vector is held before the response is checked; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request one full sweep; accepted only in IDLE.
REQ-005 dut_vec  output  3  stimulus to circuit under test, {A,B,C}, A = bit 2.
REQ-006 dut_resp  input  4  response from circuit under test, {E,F,G,H}, H = bit 0.
REQ-007 busy  output  1  high from sweep acceptance until DONE is entered.
REQ-008 done  output  1  one-cycle pulse marking the end of a sweep.
REQ-009 trojan_flag  output  1  high when mismatch_cnt != 0.
REQ-010 mismatch_cnt  output  4  number of failing vectors in the current or last sweep, 0..8.
REQ-011 fail_mask  output  8  bit i set when vector i failed.
REQ-012 first_fail_vec  output  3  index of the lowest failing vector.
REQ-013 first_fail_bits  output  4  dut_resp XOR golden at the first failure.

Function
REQ-014 Golden response for vector {A,B,C}:
- E = A&B
- F = A|C
- G = ~C
- H = A&B&C
REQ-015 FSM states and transitions:
- IDLE: start=1 -> SETTLE.
- SETTLE: stay while cnt < SETTLE-1; at cnt = SETTLE-1 -> CHECK.
- CHECK: vec = 7 -> DONE; otherwise -> SETTLE.
- DONE: -> IDLE unconditionally.
REQ-016 Start acceptance in IDLE, same edge:
- dut_vec <= 0, cnt <= 0
- mismatch_cnt, fail_mask, first_fail_vec and first_fail_bits cleared to 0.
REQ-017 SETTLE: cnt increments each cycle; dut_vec is held constant.
REQ-018 CHECK: compare dut_resp sampled this cycle against the golden response of dut_vec. On mismatch:
- set fail_mask[dut_vec]
- increment mismatch_cnt
- if this is the first failure of the sweep, load first_fail_vec and first_fail_bits.
REQ-019 CHECK, when vec != 7: dut_vec <= dut_vec + 1, cnt <= 0. dut_vec never wraps within a sweep.
REQ-020 Each vector occupies exactly SETTLE+1 cycles. DONE is entered 8*(SETTLE+1) edges after start acceptance.
REQ-021 done = 1 only in DONE. busy = 1 in SETTLE and CHECK only.
REQ-022 All result outputs hold their values from DONE until the next start acceptance.
REQ-023 start is ignored outside IDLE, including in DONE. start held high continuously re-arms a sweep on the first IDLE cycle after DONE.
REQ-024 dut_vec holds its last value (7) while IDLE after a sweep.
REQ-025 mismatch_cnt saturates at 8 by construction; no overflow path exists.
REQ-026 All outputs are registered; none depends combinationally on dut_resp.

Reset
REQ-027 While rst_n = 0 at a rising edge:
- state <= IDLE, cnt <= 0, dut_vec <= 0
- busy = 0, done = 0, trojan_flag = 0
- mismatch_cnt = 0, fail_mask = 0, first_fail_vec = 0, first_fail_bits = 0.
REQ-028 Reset mid-sweep abandons the sweep with no done pulse. start sampled in the same cycle as rst_n = 0 is ignored.

Verification
REQ-029 Golden DUT model, SETTLE=2, start pulse -> done 24 edges after acceptance; mismatch_cnt=0, fail_mask=0x00, trojan_flag=0.
REQ-030 DUT with H = A&B&C | ~(A&~C) -> results after done:
- mismatch_cnt=5, fail_mask=0x2F
- first_fail_vec=0, first_fail_bits=4'b0001
- trojan_flag=1.
REQ-031 DUT with G stuck-at-0 -> mismatch_cnt=4, fail_mask=0x55, first_fail_vec=0, first_fail_bits=4'b0010.
REQ-032 rst_n low for one cycle while dut_vec=3 -> next cycle state IDLE, all outputs at reset values, no done pulse; a new start completes a normal sweep.
REQ-033 start pulsed during a sweep -> sweep timing and results unchanged. start held high -> back-to-back sweeps, each with one done pulse and results cleared on re-acceptance.
REQ-034 SETTLE=1 -> each vector held 2 cycles; done 16 edges after acceptance.
